// File: rtl/enc16to4_scan.sv
// Sequential 16-to-4 encoder: captures a request vector and hands out the
// index of each set bit, lowest first, one per Valid/Ready transfer.
module enc16to4_scan (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [0:15] W,
    input  logic        Load,
    input  logic        Ready,
    output logic [3:0]  Y,
    output logic        Valid,
    output logic        Busy,
    output logic [4:0]  Count,
    output logic        Done
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q, state_d;
    logic [0:15] pend_q, pend_d;
    logic        done_q, done_d;

    logic [3:0]  y_c;
    logic        found_c;
    logic [4:0]  cnt_c;

    // Fixed-priority search: bit 0 wins, so codes leave in ascending order.
    always_comb begin
        y_c     = 4'd0;
        found_c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found_c && pend_q[i]) begin
                y_c     = 4'(i);
                found_c = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt_c = cnt_c + {4'd0, pend_q[i]};
        end
    end

    always_comb begin
        pend_d  = pend_q;
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    if (|W) begin
                        pend_d  = W;
                        state_d = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                // Load is deliberately ignored here, even on the final transfer edge.
                if (Ready) begin
                    pend_d[y_c] = 1'b0;
                    if (pend_d == 16'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                pend_d  = 16'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            pend_q  <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    // All outputs come from flops only; Ready never reaches Y within a cycle.
    assign Valid = (state_q == SCAN);
    assign Busy  = (state_q == SCAN);
    assign Y     = Valid ? y_c : 4'd0;
    assign Count = cnt_c;
    assign Done  = done_q;

endmodule

// File: tb/tb_enc16to4_scan.sv
// Directed and randomised-vector bench for enc16to4_scan.
module tb_enc16to4_scan;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [0:15] W = '0;
    logic        Load = 1'b0;
    logic        Ready = 1'b0;
    logic [3:0]  Y;
    logic        Valid;
    logic        Busy;
    logic [4:0]  Count;
    logic        Done;

    int total = 0;
    int bad   = 0;

    enc16to4_scan dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .W     (W),
        .Load  (Load),
        .Ready (Ready),
        .Y     (Y),
        .Valid (Valid),
        .Busy  (Busy),
        .Count (Count),
        .Done  (Done)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // v[i] set means code i pending; maps onto the ascending-index W port.
    task automatic set_w(input logic [15:0] v);
        for (int i = 0; i < 16; i++) W[i] = v[i];
    endtask

    task automatic test_reset();
        total++; if ({Y, Valid, Busy, Count, Done} !== 12'd0) begin bad++;
            $display("FAIL reset_init got %h want 0", {Y, Valid, Busy, Count, Done}); end
        Resetn = 1'b1;
        set_w(16'hFFFF); Load = 1'b1; Ready = 1'b0;
        tick();
        Load = 1'b0;
        total++; if (Busy !== 1'b1 || Count !== 5'd16) begin bad++;
            $display("FAIL reset_preload busy=%b count=%0d want 1/16", Busy, Count); end
        tick();
        #2 Resetn = 1'b0;
        #1;
        total++; if ({Y, Valid, Busy, Count, Done} !== 12'd0) begin bad++;
            $display("FAIL reset_async got %h want 0", {Y, Valid, Busy, Count, Done}); end
        @(negedge Clock);
        Resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (Busy !== 1'b0 || Count !== 5'd0 || Done !== 1'b0) begin bad++;
                $display("FAIL reset_after busy=%b count=%0d done=%b want 0/0/0", Busy, Count, Done); end
        end
    endtask

    task automatic test_sparse();
        logic [3:0] ey [3] = '{4'd3, 4'd7, 4'd15};
        set_w(16'h8088); Load = 1'b1; Ready = 1'b1;
        tick();
        Load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (Valid !== 1'b1 || Busy !== 1'b1 || Y !== ey[k] || Count !== 5'(3 - k) || Done !== 1'b0) begin bad++;
                $display("FAIL sparse_%0d v=%b y=%0d cnt=%0d done=%b want 1/%0d/%0d/0", k, Valid, Y, Count, Done, ey[k], 3 - k); end
            tick();
        end
        total++; if (Done !== 1'b1 || Busy !== 1'b0 || Valid !== 1'b0 || Y !== 4'd0) begin bad++;
            $display("FAIL sparse_done done=%b busy=%b valid=%b y=%0d want 1/0/0/0", Done, Busy, Valid, Y); end
        tick();
        total++; if (Done !== 1'b0) begin bad++;
            $display("FAIL sparse_done_pulse done=%b want 0", Done); end
    endtask

    task automatic test_backpressure();
        int dones = 0;
        set_w(16'h0201); Load = 1'b1; Ready = 1'b0;
        tick();
        Load = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++; if (Valid !== 1'b1 || Y !== 4'd0 || Count !== 5'd2) begin bad++;
                $display("FAIL bp_stall_%0d v=%b y=%0d cnt=%0d want 1/0/2", c, Valid, Y, Count); end
            if (Done) dones++;
            tick();
        end
        Ready = 1'b1;
        total++; if (Y !== 4'd0 || Count !== 5'd2) begin bad++;
            $display("FAIL bp_first y=%0d cnt=%0d want 0/2", Y, Count); end
        if (Done) dones++;
        tick();
        total++; if (Valid !== 1'b1 || Y !== 4'd9 || Count !== 5'd1) begin bad++;
            $display("FAIL bp_second v=%b y=%0d cnt=%0d want 1/9/1", Valid, Y, Count); end
        if (Done) dones++;
        tick();
        if (Done) dones++;
        tick();
        if (Done) dones++;
        total++; if (dones !== 1) begin bad++;
            $display("FAIL bp_done_count got %0d want 1", dones); end
    endtask

    task automatic test_full();
        set_w(16'hFFFF); Load = 1'b1; Ready = 1'b1;
        tick();
        Load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            total++; if (Valid !== 1'b1 || Y !== 4'(k) || Count !== 5'(16 - k) || Done !== 1'b0) begin bad++;
                $display("FAIL full_%0d v=%b y=%0d cnt=%0d done=%b want 1/%0d/%0d/0", k, Valid, Y, Count, Done, k, 16 - k); end
            tick();
        end
        total++; if (Done !== 1'b1 || Busy !== 1'b0 || Count !== 5'd0) begin bad++;
            $display("FAIL full_done done=%b busy=%b cnt=%0d want 1/0/0", Done, Busy, Count); end
        tick();
    endtask

    task automatic test_empty_and_ignored();
        set_w(16'h0000); Load = 1'b1; Ready = 1'b0;
        tick();
        Load = 1'b0;
        total++; if (Done !== 1'b1 || Valid !== 1'b0 || Busy !== 1'b0) begin bad++;
            $display("FAIL empty_done done=%b v=%b busy=%b want 1/0/0", Done, Valid, Busy); end
        tick();
        total++; if (Done !== 1'b0 || Valid !== 1'b0) begin bad++;
            $display("FAIL empty_after done=%b v=%b want 0/0", Done, Valid); end
        set_w(16'h0020); Load = 1'b1;
        tick();
        set_w(16'h0004);
        tick();
        total++; if (Valid !== 1'b1 || Y !== 4'd5 || Count !== 5'd1) begin bad++;
            $display("FAIL ignored_scan v=%b y=%0d cnt=%0d want 1/5/1", Valid, Y, Count); end
        Ready = 1'b1;
        tick();
        Load = 1'b0;
        total++; if (Done !== 1'b1 || Valid !== 1'b0 || Busy !== 1'b0 || Count !== 5'd0) begin bad++;
            $display("FAIL ignored_final done=%b v=%b busy=%b cnt=%0d want 1/0/0/0", Done, Valid, Busy, Count); end
        tick();
        total++; if (Valid !== 1'b0 || Count !== 5'd0) begin bad++;
            $display("FAIL ignored_idle v=%b cnt=%0d want 0/0", Valid, Count); end
    endtask

    task automatic test_round_trip();
        logic [15:0] v, acc, dec;
        int cyc;
        for (int n = 0; n < 200; n++) begin
            v = 16'($urandom);
            if (n % 50 == 7) v = 16'h0;
            set_w(v); Load = 1'b1; Ready = 1'($urandom);
            tick();
            Load = 1'b0;
            acc = '0;
            cyc = 0;
            while (Busy && cyc < 200) begin
                Ready = 1'($urandom);
                #1;
                // Behavioural 4-to-16 decoder with En=Valid.
                dec = '0;
                if (Valid) dec[Y] = 1'b1;
                if (Valid && Ready) begin
                    total++; if ((dec & acc) !== 16'd0 || (dec & v) !== dec) begin bad++;
                        $display("FAIL rt_%0d_xfer dec=%h acc=%h w=%h", n, dec, acc, v); end
                    acc = acc | dec;
                end
                tick();
                cyc++;
            end
            total++; if (acc !== v || Done !== 1'b1 || cyc >= 200) begin bad++;
                $display("FAIL rt_%0d_end acc=%h want %h done=%b cyc=%0d", n, acc, v, Done, cyc); end
        end
        tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_sparse();
        test_backpressure();
        test_full();
        test_empty_and_ignored();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc16to4_scan.md
# enc16to4_scan

Sequential 16-to-4 encoder, the inverse of the team's 4-to-16 decoder: it captures a 16-bit request vector and emits, one per handshake, the 4-bit code of every set bit, lowest bit position first. Bit ordering matches the decoder output, so W[0] encodes to 0 and W[15] encodes to 15. The block sits between a 16-line request/flag source and any consumer that needs binary indices, such as a decoder-driven select bus, a register-file address port or a logger.

## Interface
Parameters: none. Widths are fixed at 16 in and 4 out.
- Clock  in  1  rising-edge clock; the only clock
- Resetn  in  1  reset, asynchronous, active-low
- W  in  [0:15]  request vector; W[i] set means code i is pending
- Load  in  1  capture W; honoured only in IDLE
- Ready  in  1  consumer accepts Y this cycle
- Y  out  [3:0]  code of the lowest-numbered pending bit; 0 when not Valid
- Valid  out  1  Y holds a pending code
- Busy  out  1  high in SCAN; Load is ignored while high
- Count  out  [4:0]  number of pending bits, 0..16
- Done  out  1  one-cycle pulse when a captured vector is fully drained

## Operation
- Internal state: pending register P[0:15], state in {IDLE, SCAN}, and a Done flop.
- IDLE:
  - Busy=0 and Valid=0.
  - Load=1 and W nonzero: P<=W, state<=SCAN.
  - Load=1 and W all zero: P stays 0, state stays IDLE, Done<=1 for one cycle.
  - Load=0: hold.
- SCAN:
  - Valid=1, Busy=1.
  - Y = smallest i with P[i]=1, fixed-priority search with bit 0 highest.
- Handshake: a transfer occurs on a rising edge where Valid=1 and Ready=1. That edge clears P[Y].
  - If the cleared bit was the last one set, state<=IDLE and Done<=1 for one cycle.
- Valid=1 with Ready=0: P, Y and Count hold stable. Y must not change while Valid is high and no transfer has occurred.
- Load asserted during SCAN has no effect. W is sampled only on a Load edge in IDLE.
- Count = popcount(P), computed combinationally from P. It reads 0 in IDLE.
- Y, Valid, Busy and Count derive only from registered state. They are glitch-free with respect to W, Load and Ready; there is no combinational path from Ready to Y.
- Round-trip property: driving Y into the 4-to-16 decoder with En=Valid reproduces, cycle by cycle, exactly the bit being cleared from P.

## Timing
- Reset (Resetn=0, asynchronous, takes effect immediately):
  - P=0, state=IDLE, Done=0.
  - Outputs: Y=0, Valid=0, Busy=0, Count=0, Done=0.
- Deasserting Resetn is synchronised by the surrounding design. The first Load is honoured on the first rising edge with Resetn=1.
- Reset mid-SCAN discards all pending codes. No Done pulse is produced.
- Latency: Load sampled at edge k gives Valid=1 with the first Y from edge k onward, i.e. visible in cycle k+1.
- Throughput: one code per cycle while Ready is held high. An N-bit vector drains in exactly N cycles.
  - Done is high in the cycle after the N-th transfer edge.
  - The next Load is accepted on that same edge or later.
- Load=1 on the same edge as the final transfer is ignored, because state is still SCAN. The vector must be reloaded once Busy=0.
- Empty load: Done is high in cycle k+1. Busy and Valid never rise.
- Ready is don't-care while Valid=0.

## Test plan
- Reset: assert Resetn=0 asynchronously mid-SCAN with W=16'hFFFF loaded -> all outputs 0 immediately; after release, Busy=0, Count=0 and no Done pulse.
- Sparse vector, Ready held 1: Load W with bits 3, 7 and 15 set -> Y=3, 7, 15 on three consecutive cycles with Count=3, 2, 1; Done pulses in the 4th cycle; Busy falls at the same time.
- Backpressure: Load W with bits 0 and 9 set, Ready=0 for 5 cycles, then 1 -> Y=0 held stable and Count=2 throughout the stall; then Y=0, then Y=9; Done pulses once.
- Full vector: Load 16'hFFFF with Ready=1 -> Y counts 0..15 over 16 cycles; Count goes 16 down to 1; Done on cycle 17.
- Empty and ignored loads: Load W=0 -> Done pulses, Valid stays 0. Load bit 5 set, then in SCAN Load bit 2 set -> only code 5 is emitted.
- Round-trip: feed Y into dec4to16 with En=Valid for 200 random vectors with random Ready -> decoder outputs OR-accumulate to each loaded W exactly, one-hot per transfer, no duplicates.
